// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding and default configuration for the CNN layer scheduler
package cnn_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_WAIT_DONE,
        S_NEXT,
        S_FINISH,
        S_ERROR
    } sched_state_t;
    localparam int CNN_NUM_LAYERS = 4;
    localparam int CNN_TIMEOUT = 1023;
    // layer 0 consumes one 187-sample ECG window; later layers read on-chip buffers
    localparam int unsigned CNN_FEED_BEATS [CNN_NUM_LAYERS] = '{187, 0, 0, 0};
endpackage

// File: rtl/sched_watchdog.sv
// sched_watchdog: saturating per-layer cycle counter; expired flags the TIMEOUT-th counted cycle
module sched_watchdog #(
    parameter int TIMEOUT = 1023,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else cnt <= clr ? '0 : (en && cnt != CW'(TIMEOUT)) ? cnt + 1'b1 : cnt;
    assign expired = en && (cnt >= CW'(TIMEOUT - 1));
endmodule

// File: rtl/cnn_layer_scheduler.sv
// cnn_layer_scheduler: sequences the layer controllers for one inference, feeding external
// samples to layers that consume them and aborting on watchdog expiry or an early done.
module cnn_layer_scheduler
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = CNN_NUM_LAYERS,
    parameter int BEAT_W = 8,
    parameter int unsigned FEED_BEATS [NUM_LAYERS] = CNN_FEED_BEATS,
    parameter int TIMEOUT = CNN_TIMEOUT,
    localparam int LW = $clog2(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LW-1:0]         layer_sel,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] feed_valid,
    input  logic                  src_valid,
    output logic                  src_ready
);
    sched_state_t state, state_d;
    logic [BEAT_W-1:0] beats_tab [NUM_LAYERS];
    logic [BEAT_W-1:0] beat_cnt, cur_beats;
    logic busy_d, done_d, err_d;
    logic [LW-1:0] sel_d;
    logic [NUM_LAYERS-1:0] start_d;
    logic cur_done, accept, last_beat, last_layer, wd_exp;

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_beats
        if (64'(FEED_BEATS[i]) >= (64'd1 << BEAT_W)) begin : g_range
            $error("FEED_BEATS entry does not fit in BEAT_W bits");
        end
        assign beats_tab[i] = BEAT_W'(FEED_BEATS[i]);
    end

    assign cur_beats  = beats_tab[layer_sel];
    assign cur_done   = layer_done[layer_sel];
    assign src_ready  = state == S_FEED;
    assign accept     = src_ready && src_valid;
    assign last_beat  = accept && (beat_cnt + 1'b1 == cur_beats);
    assign last_layer = layer_sel == LW'(NUM_LAYERS - 1);
    assign feed_valid = accept ? NUM_LAYERS'(1) << layer_sel : '0;

    sched_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == S_START),
        .en      (state == S_FEED || state == S_WAIT_DONE),
        .expired (wd_exp)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_IDLE;
        else state <= state_d;

    // expiry outranks everything; a done that lands with the last beat still counts as complete
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:      state_d = run ? S_START : S_IDLE;
            S_START:     state_d = (cur_beats == '0) ? S_WAIT_DONE : S_FEED;
            S_FEED:      state_d = wd_exp ? S_ERROR : (last_beat && cur_done) ? S_NEXT :
                                   last_beat ? S_WAIT_DONE : cur_done ? S_ERROR : S_FEED;
            S_WAIT_DONE: state_d = wd_exp ? S_ERROR : cur_done ? S_NEXT : S_WAIT_DONE;
            S_NEXT:      state_d = last_layer ? S_FINISH : S_START;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d  = state_d != S_IDLE;
        done_d  = state_d == S_FINISH;
        err_d   = (state_d == S_ERROR) || (err && !(state == S_IDLE && run));
        sel_d   = (state == S_IDLE) ? '0 : (state == S_NEXT && !last_layer) ? layer_sel + 1'b1 : layer_sel;
        start_d = (state_d == S_START) ? NUM_LAYERS'(1) << sel_d : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            layer_sel   <= '0;
            layer_start <= '0;
            beat_cnt    <= '0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            layer_sel   <= sel_d;
            layer_start <= start_d;
            beat_cnt    <= (state == S_START) ? '0 : accept ? beat_cnt + 1'b1 : beat_cnt;
        end
    end
endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// tb_cnn_layer_scheduler: table-driven inference scenarios plus timing, clear-on-run and async-reset sequences
module tb_cnn_layer_scheduler;
    localparam int NL = 4;
    localparam int TO = 64;
    localparam int FEED0 = 5;
    localparam int unsigned FB [NL] = '{5, 0, 0, 0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    logic src_valid = 1'b0;
    logic [NL-1:0] layer_done = '0;
    logic busy, done, err, src_ready;
    logic [1:0] layer_sel;
    logic [NL-1:0] layer_start, feed_valid;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          toggle;
        bit          spurious;
        logic [3:0]  mask;
        int          early;
        int          lat;
        int          exp_beats;
        logic [15:0] exp_seq;
        int          exp_done;
        bit          exp_err;
    } vec_t;
    vec_t vecs [5];

    int r_beats, r_done, r_viol, r_errcyc, r_ld3, r_donecyc, r_end, r_st2;
    logic [15:0] r_seq;
    logic r_err, r_busy1, r_err1;
    logic [NL-1:0] r_start1;

    always #5 clk = ~clk;

    cnn_layer_scheduler #(
        .NUM_LAYERS (NL),
        .BEAT_W     (8),
        .FEED_BEATS (FB),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .layer_sel   (layer_sel),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .feed_valid  (feed_valid),
        .src_valid   (src_valid),
        .src_ready   (src_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // cycle 0 carries run; inputs change #1 after each rising edge, outputs are sampled on the falling edge
    task automatic run_scn(input vec_t v);
        int st [NL];
        bit started [NL];
        int beats;
        bit early_sent, fin;
        beats = 0;
        early_sent = 1'b0;
        fin = 1'b0;
        r_seq = '0;
        r_done = 0;
        r_viol = 0;
        r_errcyc = -1;
        r_ld3 = -1;
        r_donecyc = -1;
        for (int i = 0; i < NL; i++) begin
            st[i] = 0;
            started[i] = 1'b0;
        end
        for (int c = 0; c < 600 && !fin; c++) begin
            @(posedge clk);
            #1;
            run = (c == 0) || (v.spurious && c == 4);
            src_valid = v.toggle ? c[0] : 1'b1;
            layer_done = '0;
            for (int i = 0; i < NL; i++)
                if (started[i] && v.mask[i] && c == st[i] + v.lat) layer_done[i] = 1'b1;
            if (layer_done[3]) r_ld3 = c;
            if (v.spurious && started[1] && c == st[1] + 2) layer_done[3] = 1'b1;
            if (v.early > 0 && !early_sent && beats == v.early) begin
                layer_done[0] = 1'b1;
                src_valid = 1'b0;
                early_sent = 1'b1;
            end
            @(negedge clk);
            if (layer_start != '0) begin
                r_seq = {r_seq[11:0], layer_start};
                for (int i = 0; i < NL; i++)
                    if (layer_start[i]) begin
                        st[i] = c;
                        started[i] = 1'b1;
                    end
            end
            if (src_ready && beats >= FEED0) r_viol++;
            if (feed_valid != '0) begin
                if (feed_valid != 4'b0001 || !src_valid || !src_ready) r_viol++;
                beats++;
            end
            if (done) begin
                r_done++;
                r_donecyc = c;
            end
            if (err && r_errcyc < 0) r_errcyc = c;
            if (c == 1) begin
                r_busy1 = busy;
                r_start1 = layer_start;
                r_err1 = err;
            end
            if (c >= 2 && !busy) begin
                fin = 1'b1;
                r_end = c;
            end
        end
        run = 1'b0;
        src_valid = 1'b0;
        layer_done = '0;
        r_beats = beats;
        r_err = err;
        r_st2 = st[2];
        chk("scenario_terminates", 32'(fin), 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'hF, 0, 10, 5, 16'h1248, 1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 0, 16, 5, 16'h1248, 1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 4'hB, 0, 10, 5, 16'h0124, 0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 3, 10, 3, 16'h0001, 0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 4'hF, 0, 10, 5, 16'h1248, 1, 1'b0};

        #12;
        chk("reset_outputs", 32'({busy, done, err, src_ready, layer_sel, layer_start, feed_valid}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 5; k++) begin
            run_scn(vecs[k]);
            chk($sformatf("v%0d_beats", k), 32'(r_beats), 32'(vecs[k].exp_beats));
            chk($sformatf("v%0d_start_seq", k), 32'(r_seq), 32'(vecs[k].exp_seq));
            chk($sformatf("v%0d_done_pulses", k), 32'(r_done), 32'(vecs[k].exp_done));
            chk($sformatf("v%0d_err", k), 32'(r_err), 32'(vecs[k].exp_err));
            chk($sformatf("v%0d_feed_protocol", k), 32'(r_viol), 32'd0);
            chk($sformatf("v%0d_busy_after_run", k), 32'(r_busy1), 32'd1);
            chk($sformatf("v%0d_first_start", k), 32'(r_start1), 32'd1);
        end

        run_scn(vecs[2]);
        chk("timeout_err_lag", 32'(r_errcyc - r_st2), 32'(TO + 1));
        chk("timeout_busy_fall", 32'(r_end), 32'(r_errcyc + 1));
        chk("timeout_no_done", 32'(r_done), 32'd0);

        run_scn(vecs[0]);
        chk("err_cleared_by_run", 32'(r_err1), 32'd0);
        chk("done_lag", 32'(r_donecyc - r_ld3), 32'd2);
        chk("done_cycle", 32'(r_donecyc), 32'd49);

        @(posedge clk);
        #1;
        run = 1'b1;
        src_valid = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_feeding", 32'(feed_valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({busy, done, err, src_ready, layer_sel, layer_start, feed_valid}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        src_valid = 1'b0;

        run_scn(vecs[0]);
        chk("post_reset_beats", 32'(r_beats), 32'd5);
        chk("post_reset_seq", 32'(r_seq), 32'h1248);
        chk("post_reset_done", 32'(r_done), 32'd1);
        chk("post_reset_err", 32'(r_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cnn_layer_scheduler.md
# cnn_layer_scheduler

Top-level sequencer for the 1-D CNN ECG classifier. It runs the layer controllers in order, layer 0 to layer NUM_LAYERS-1, for one inference. For each layer it issues a start pulse, streams input samples from the upstream sample buffer into the layer when that layer consumes external data, and waits for the layer's done pulse. It reports completion, and it aborts with a sticky error on timeout or protocol violation.

## Interface
Parameters:
- NUM_LAYERS, 4, number of layer controllers sequenced
- BEAT_W, 8, width of per-layer feed-beat counts
- FEED_BEATS, from package (`{8'd187, 8'd0, 8'd0, 8'd0}`), per-layer count of input beats to stream; 0 means the layer takes no external data
- TIMEOUT, 1023, maximum cycles allowed per layer, counted from the cycle after start until done
- Derived: LW = $clog2(NUM_LAYERS)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- run  in  1  start one inference; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted run until FINISH/ERROR exit
- done  out  1  one-cycle pulse, all layers complete
- err  out  1  sticky error; cleared when a new run is accepted
- layer_sel  out  LW  index of the active layer, used by the datapath muxes
- layer_start  out  NUM_LAYERS  one-hot, one-cycle start pulse to layer i
- layer_done  in  NUM_LAYERS  done pulses from the layer controllers
- feed_valid  out  NUM_LAYERS  one-hot data strobe to layer i (its maxflagin)
- src_valid  in  1  upstream sample available
- src_ready  out  1  scheduler accepts a sample this cycle

## Operation
- States:
  - IDLE
  - START
  - FEED
  - WAIT_DONE
  - NEXT
  - FINISH
  - ERROR
- IDLE:
  - run=1 → START, with layer index ← 0 and err ← 0.
  - run while not in IDLE is ignored.
- START:
  - layer_start[layer_sel]=1 for exactly this cycle.
  - Clear the beat counter and the watchdog.
  - If FEED_BEATS[layer_sel]==0 → WAIT_DONE; else → FEED.
- FEED:
  - src_ready=1.
  - A beat is accepted when src_valid & src_ready.
  - feed_valid[layer_sel] = src_valid & src_ready (combinational, same cycle). All other feed_valid bits are 0.
  - Beat counter increments on each accepted beat. On the beat that makes count == FEED_BEATS[layer_sel] → WAIT_DONE.
  - src_ready is 0 from the next cycle; no extra beat is ever taken.
- WAIT_DONE:
  - layer_done[layer_sel]=1 → NEXT.
- NEXT:
  - If layer_sel == NUM_LAYERS-1 → FINISH; else layer_sel+1 → START.
- FINISH:
  - done=1 for one cycle → IDLE.
- ERROR:
  - err ← 1 → IDLE. done is not pulsed.
- Watchdog:
  - Counts every cycle spent in FEED or WAIT_DONE for the current layer.
  - Reaching TIMEOUT → ERROR, regardless of other inputs that cycle.
- Protocol violation → ERROR: layer_done[layer_sel] asserted in FEED before all beats are accepted.
- layer_done bits of non-active layers are ignored in every state.
- Simultaneous events:
  - layer_done and watchdog expiry in the same WAIT_DONE cycle: expiry wins (ERROR).
  - Last beat and layer_done in the same FEED cycle: treated as complete → NEXT.
- Reset values: busy, done, err, src_ready, layer_start, feed_valid all 0; layer_sel 0; state IDLE.
- Reset mid-operation aborts immediately: no done, err=0.

## Timing
- Run accepted at edge t → busy=1 and layer_start[0]=1 in cycle t+1.
- A layer with zero beats: start cycle, then WAIT_DONE from the next cycle.
- Per-layer overhead: START (1) + NEXT (1) cycles, plus feed and layer latency.
- done pulses 2 cycles after the last layer_done is sampled (NEXT, then FINISH).
- busy falls in the cycle after FINISH or ERROR.
- Beat counter and watchdog are unsigned. The watchdog is $clog2(TIMEOUT+1) bits and never wraps, since it saturates at TIMEOUT.
- FEED_BEATS values must be < 2^BEAT_W; this is checked by an elaboration assertion.

## Structure
- Shared package `cnn_pkg` holds:
  - the state enum typedef
  - NUM_LAYERS
  - the default FEED_BEATS array (187 ECG samples for layer 0)
  - the TIMEOUT constant
- Sub-module `sched_watchdog`: saturating counter with clear and enable inputs and an expired output.
- Everything else is one FSM module; all outputs except feed_valid and src_ready are registered.

## Test plan
- Nominal run: FEED_BEATS={5,0,0,0}, src_valid held high, layer i done 10 cycles after its start → 5 feed_valid[0] pulses, layer_start sequence 1,2,4,8, single done pulse, err=0.
- Backpressure: src_valid toggling 1/0 during FEED → exactly 5 beats accepted, src_ready low immediately after the 5th, feed_valid only on accepted cycles.
- Timeout: layer 2 never asserts done → err=1 exactly TIMEOUT cycles after layer_start[2] plus 1, no done pulse, busy low, next run clears err.
- Early done: layer_done[0] after 3 of 5 beats → ERROR, err=1, layer_start[1] never issued.
- Reset mid-FEED: rst low after beat 2 → all outputs 0 asynchronously; a new run restarts from layer 0 with a full 5-beat feed.
- Spurious inputs: run pulsed while busy, and layer_done[3] pulsed during layer 1 → both ignored, sequence completes normally.
